// File: rtl/rle_pair_fifo.sv
// Elastic pair buffer between the 8-wide RLE stage and the 1-wide Huffman coder.
// Optional feature: define RLE_FIFO_EOB_EN to append an explicit {0,0} end-of-block marker.
module rle_pair_fifo #(
   parameter int DEPTH = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [95:0] in_pairs,
   input  logic [3:0]  in_count,
   input  logic        in_last,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [3:0]  out_run,
   output logic [7:0]  out_value,
   output logic        out_eob,
   output logic        out_valid,
   input  logic        out_ready
);

   localparam int AW = $clog2(DEPTH);
`ifdef RLE_FIFO_EOB_EN
   localparam logic [AW:0] THRESH = (AW+1)'(9);
`else
   localparam logic [AW:0] THRESH = (AW+1)'(8);
`endif

   logic [12:0]   r_mem [DEPTH];
   logic [AW-1:0] r_wp;
   logic [AW-1:0] r_rp;
   logic [AW:0]   r_cnt;

   logic [3:0]    w_n;
   logic [3:0]    w_nwr;
   logic          w_push;
   logic          w_pop;
   logic [AW:0]   w_free;
   logic [12:0]   w_head;
   logic [12:0]   w_entry [16];
   logic [AW-1:0] w_off [DEPTH];
   logic          w_we [DEPTH];
   logic [12:0]   w_wd [DEPTH];

   assign w_n = (in_count > 4'd8) ? 4'd8 : in_count;
`ifdef RLE_FIFO_EOB_EN
   assign w_nwr = w_n + {3'b000, in_last};
`else
   assign w_nwr = w_n;
`endif

   assign w_free    = (AW+1)'(DEPTH) - r_cnt;
   assign in_ready  = (w_free >= THRESH);
   assign out_valid = (r_cnt != '0);
   assign w_push    = in_valid && in_ready;
   assign w_pop     = out_valid && out_ready;

   // Compacted group: entries 0..w_nwr-1 land at wp, wp+1, ... in order.
   always_comb begin
      for (int k = 0; k < 16; k++) w_entry[k] = '0;
      for (int k = 0; k < 8; k++) begin
         if (4'(k) < w_n) w_entry[k] = {1'b0, in_pairs[k*12 +: 12]};
      end
`ifdef RLE_FIFO_EOB_EN
      if (in_last) w_entry[w_n] = 13'h1000;
`else
      if (in_last && (w_n != 4'd0)) w_entry[w_n - 4'd1][12] = 1'b1;
`endif
   end

   always_comb begin
      for (int j = 0; j < DEPTH; j++) begin
         w_off[j] = AW'(j) - r_wp;
         w_we[j]  = w_push && (w_off[j] < AW'(w_nwr));
         w_wd[j]  = w_entry[w_off[j][3:0]];
      end
   end

   always_ff @(posedge clk) begin
      for (int j = 0; j < DEPTH; j++) begin
         if (w_we[j]) r_mem[j] <= w_wd[j];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wp  <= '0;
         r_rp  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_push) r_wp <= r_wp + AW'(w_nwr);
         if (w_pop)  r_rp <= r_rp + AW'(1);
         r_cnt <= r_cnt + (w_push ? (AW+1)'(w_nwr) : '0) - (AW+1)'(w_pop);
      end
   end

   // Head pair is forced to zero while the buffer is empty.
   assign w_head = r_mem[r_rp];
   assign {out_eob, out_run, out_value} = out_valid ? w_head : 13'h0000;

endmodule
